prio_arbiter: RTL and testbench

//   Parametrised, registered N-way arbiter and priority encoder with a valid/ready grant port.

---
 rtl/prio_arbiter_if.sv | 25 ++
 rtl/prio_arbiter.sv | 96 +++++++++
 tb/tb_prio_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/prio_arbiter_if.sv
// Grant port bundle between N requesters, the arbiter and the shared resource.
// The master side is the arbiter; the slave side is the requester/downstream logic.
interface prio_arbiter_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic             mode;
    logic             gnt_ready;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic             idle;

    modport master (
        input  req, mode, gnt_ready,
        output gnt_valid, gnt_idx, gnt_onehot, idle
    );

    modport slave (
        output req, mode, gnt_ready,
        input  gnt_valid, gnt_idx, gnt_onehot, idle
    );
endinterface

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed priority (highest index) or round-robin,
// with a valid/ready grant that is held until the downstream side accepts it.
module prio_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    prio_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic             gnt_rr;

    logic             handshake_c;
    logic             load_c;
    logic             hit_c;
    logic [N-1:0]     masked_c;
    logic [IDX_W-1:0] fix_idx_c;
    logic [IDX_W-1:0] rr_idx_c;
    logic             rr_found_c;
    logic [IDX_W-1:0] win_c;
    logic [IDX_W-1:0] ptr_next_c;

    assign handshake_c = (state == GRANT) && bus.gnt_valid && bus.gnt_ready;
    // The just-accepted requester sits out only the arbitration on its own handshake edge.
    assign masked_c    = handshake_c ? (bus.req & ~bus.gnt_onehot) : bus.req;
    assign hit_c       = |masked_c;
    assign load_c      = hit_c && ((state == IDLE) || handshake_c);
    assign win_c       = bus.mode ? rr_idx_c : fix_idx_c;
    assign ptr_next_c  = (bus.gnt_idx == IDX_W'(N - 1)) ? '0 : bus.gnt_idx + IDX_W'(1);

    // Fixed priority: last set bit seen in an ascending scan is the highest index.
    always_comb begin
        fix_idx_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (masked_c[i]) begin
                fix_idx_c = IDX_W'(i);
            end
        end
    end

    // Round-robin: first set bit scanning up from rr_ptr, wrapping at N (not 2^IDX_W).
    always_comb begin
        int unsigned j;
        j          = 0;
        rr_idx_c   = '0;
        rr_found_c = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!rr_found_c && masked_c[IDX_W'(j)]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gnt_rr         <= 1'b0;
            bus.gnt_valid  <= 1'b0;
            bus.gnt_idx    <= '0;
            bus.gnt_onehot <= '0;
            bus.idle       <= 1'b1;
        end else begin
            // Pointer only advances for grants that were won under round-robin.
            if (handshake_c && gnt_rr) begin
                rr_ptr <= ptr_next_c;
            end
            if (load_c) begin
                state          <= GRANT;
                gnt_rr         <= bus.mode;
                bus.gnt_valid  <= 1'b1;
                bus.gnt_idx    <= win_c;
                bus.gnt_onehot <= N'(1) << win_c;
                bus.idle       <= 1'b0;
            end else if (handshake_c) begin
                state          <= IDLE;
                bus.gnt_valid  <= 1'b0;
                bus.gnt_onehot <= '0;
                bus.idle       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N = 8): reset, fixed/round-robin selection,
// held grants, back-to-back grants, pointer wrap and reset during a grant.
module tb_prio_arbiter;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prio_arbiter_if #(.N(N)) bus ();
    prio_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.mode = 1'b0; bus.gnt_ready = 1'b0;
        apply_reset();
        checks++;
        if (bus.gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.gnt_valid); end
        checks++;
        if (bus.gnt_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.gnt_idx); end
        checks++;
        if (bus.gnt_onehot !== 8'h00) begin failures++; $display("FAIL reset_onehot got=%h exp=00", bus.gnt_onehot); end
        checks++;
        if (bus.idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", bus.idle); end
        checks++;
        if (dut.rr_ptr !== 3'd0) begin failures++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    endtask

    task automatic test_fixed();
        bus.req = '0; bus.mode = 1'b0; bus.gnt_ready = 1'b0;
        apply_reset();
        bus.req = 8'b0010_0100; bus.gnt_ready = 1'b1;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd5 || bus.gnt_onehot !== 8'b0010_0000 || bus.idle !== 1'b0) begin
            failures++;
            $display("FAIL fixed_first got v=%0b idx=%0d oh=%b idle=%0b exp v=1 idx=5 oh=00100000 idle=0",
                     bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.idle);
        end
        step();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd2 || bus.gnt_onehot !== 8'b0000_0100) begin
            failures++;
            $display("FAIL fixed_masked got v=%0b idx=%0d oh=%b exp v=1 idx=2 oh=00000100",
                     bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
        end
        bus.req = '0;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 8'h00 || bus.idle !== 1'b1) begin
            failures++;
            $display("FAIL fixed_drain got v=%0b oh=%b idle=%0b exp v=0 oh=00000000 idle=1",
                     bus.gnt_valid, bus.gnt_onehot, bus.idle);
        end
    endtask

    task automatic test_idle();
        bus.req = '0; bus.mode = 1'b0; bus.gnt_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 8'h00 || bus.idle !== 1'b1) begin
                failures++;
                $display("FAIL idle_cycle%0d got v=%0b oh=%b idle=%0b exp v=0 oh=00000000 idle=1",
                         c, bus.gnt_valid, bus.gnt_onehot, bus.idle);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_idx;
        bus.req = 8'hFF; bus.mode = 1'b1; bus.gnt_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            step();
            exp_idx = 3'(c % 8);
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== exp_idx || bus.gnt_onehot !== (8'h01 << exp_idx)) begin
                failures++;
                $display("FAIL rr_seq%0d got v=%0b idx=%0d oh=%b exp v=1 idx=%0d",
                         c, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, exp_idx);
            end
        end
    endtask

    task automatic test_hold();
        bus.req = 8'b0010_0100; bus.mode = 1'b0; bus.gnt_ready = 1'b0;
        apply_reset();
        step();
        bus.req = 8'h80;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus.mode = 1'b1;
            step();
            checks++;
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd5 || bus.gnt_onehot !== 8'b0010_0000) begin
                failures++;
                $display("FAIL hold_cycle%0d got v=%0b idx=%0d oh=%b exp v=1 idx=5 oh=00100000",
                         c, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
            end
        end
        bus.mode = 1'b0; bus.gnt_ready = 1'b1;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd7 || bus.gnt_onehot !== 8'h80) begin
            failures++;
            $display("FAIL hold_release got v=%0b idx=%0d oh=%b exp v=1 idx=7 oh=10000000",
                     bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
        end
    endtask

    task automatic test_rr_wrap();
        bus.req = 8'b0100_0000; bus.mode = 1'b1; bus.gnt_ready = 1'b0;
        apply_reset();
        step();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd6) begin
            failures++; $display("FAIL wrap_first got v=%0b idx=%0d exp v=1 idx=6", bus.gnt_valid, bus.gnt_idx);
        end
        bus.gnt_ready = 1'b1;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.idle !== 1'b1 || dut.rr_ptr !== 3'd7) begin
            failures++;
            $display("FAIL wrap_ptr7 got v=%0b idle=%0b ptr=%0d exp v=0 idle=1 ptr=7", bus.gnt_valid, bus.idle, dut.rr_ptr);
        end
        bus.req = 8'b0000_0011; bus.gnt_ready = 1'b0;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd0 || bus.gnt_onehot !== 8'h01) begin
            failures++;
            $display("FAIL wrap_grant got v=%0b idx=%0d oh=%b exp v=1 idx=0 oh=00000001",
                     bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
        end
        bus.req = '0; bus.gnt_ready = 1'b1;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b0 || dut.rr_ptr !== 3'd1) begin
            failures++; $display("FAIL wrap_ptr1 got v=%0b ptr=%0d exp v=0 ptr=1", bus.gnt_valid, dut.rr_ptr);
        end
    endtask

    task automatic test_reset_mid_grant();
        bus.req = 8'hFF; bus.mode = 1'b1; bus.gnt_ready = 1'b1;
        apply_reset();
        step();
        step();
        step();
        bus.gnt_ready = 1'b0;
        step();
        checks++;
        if (bus.gnt_idx !== 3'd2 || dut.rr_ptr !== 3'd2) begin
            failures++; $display("FAIL midrst_pre got idx=%0d ptr=%0d exp idx=2 ptr=2", bus.gnt_idx, dut.rr_ptr);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.idle !== 1'b1 || bus.gnt_onehot !== 8'h00 || dut.rr_ptr !== 3'd0) begin
            failures++;
            $display("FAIL midrst_clear got v=%0b idle=%0b oh=%b ptr=%0d exp v=0 idle=1 oh=00000000 ptr=0",
                     bus.gnt_valid, bus.idle, bus.gnt_onehot, dut.rr_ptr);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd0) begin
            failures++; $display("FAIL midrst_regrant got v=%0b idx=%0d exp v=1 idx=0", bus.gnt_valid, bus.gnt_idx);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_fixed();
        test_idle();
        test_back_to_back();
        test_hold();
        test_rr_wrap();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
